// File: rtl/rx_engine.sv
// rx_engine: asynchronous serial receiver with 7/8 data bits, optional parity, framing and overflow flags.
// Define RX_SYNC_EN to pass RX through a two-flop synchronizer (adds two clk of latency).
`timescale 1ns/1ps
module rx_engine (
   input  logic        clk,
   input  logic        reset,
   input  logic        RX,
   input  logic [18:0] K,
   input  logic        EIGHT,
   input  logic        PEN,
   input  logic        OHEL,
   input  logic        CLR_RDY,
   output logic [7:0]  RDATA,
   output logic        RXRDY,
   output logic        PERR,
   output logic        FERR,
   output logic        OVF
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t      state_q, state_d;
   logic [18:0] tmr_q, tmr_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [8:0]  sh_q, sh_d;
   logic        eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
   logic        rxp_q;
   logic        rx, tick, done, pbit;
   logic [3:0]  last;
   logic [7:0]  data;

`ifdef RX_SYNC_EN
   logic [1:0] sync_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], RX};
   assign rx = sync_q[1];
`else
   assign rx = RX;
`endif

   // the timer "reaches 0" on the edge where it decrements from 1, giving exact K-cycle bit periods
   assign tick = tmr_q == 19'd1;
   assign done = state_q == STOP && tick;
   assign last = 4'd6 + {3'b000, eight_q} + {3'b000, pen_q};
   assign data = eight_q ? sh_q[7:0] : {1'b0, sh_q[6:0]};
   assign pbit = eight_q ? sh_q[8] : sh_q[7];

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      eight_d  = eight_q;
      pen_d    = pen_q;
      ohel_d   = ohel_q;
      rdata_d  = rdata_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      case (state_q)
         IDLE: begin
            // a falling edge is required, so a line held low across reset release is ignored
            if (!rx && rxp_q) begin
               state_d  = START;
               tmr_d    = K >> 1;
               bitcnt_d = 4'd0;
               sh_d     = 9'd0;
            end
         end
         START: begin
            if (!tick) tmr_d = tmr_q - 19'd1;
            else if (rx) begin
               state_d = IDLE;
               tmr_d   = 19'd0;
            end else begin
               state_d = DATA;
               tmr_d   = K;
               eight_d = EIGHT;
               pen_d   = PEN;
               ohel_d  = OHEL;
            end
         end
         DATA: begin
            if (!tick) tmr_d = tmr_q - 19'd1;
            else begin
               sh_d[bitcnt_q] = rx;
               tmr_d          = K;
               bitcnt_d       = bitcnt_q + 4'd1;
               state_d        = bitcnt_q == last ? STOP : DATA;
            end
         end
         STOP: begin
            if (!tick) tmr_d = tmr_q - 19'd1;
            else begin
               state_d = IDLE;
               tmr_d   = 19'd0;
               rdata_d = data;
               perr_d  = pen_q & (pbit != (^data ^ ohel_q));
               ferr_d  = ~rx;
            end
         end
      endcase
      rxrdy_d = done | (rxrdy_q & ~CLR_RDY);
      ovf_d   = done ? rxrdy_q : ovf_q & ~CLR_RDY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         tmr_q    <= 19'd0;
         bitcnt_q <= 4'd0;
         sh_q     <= 9'd0;
         eight_q  <= 1'b0;
         pen_q    <= 1'b0;
         ohel_q   <= 1'b0;
         rdata_q  <= 8'h00;
         rxrdy_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rxp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         eight_q  <= eight_d;
         pen_q    <= pen_d;
         ohel_q   <= ohel_d;
         rdata_q  <= rdata_d;
         rxrdy_q  <= rxrdy_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
         rxp_q    <= rx;
      end
   end

   assign RDATA = rdata_q;
   assign RXRDY = rxrdy_q;
   assign PERR  = perr_q;
   assign FERR  = ferr_q;
   assign OVF   = ovf_q;
endmodule

// File: doc/rx_engine.md
RX_ENGINE -- requirements
Module: rx_engine

Interface
REQ-001 Parameters: none; all framing and timing is set by ports.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 RX  in  1  serial line; idle high.
REQ-005 K  in  19  bit time in clk cycles; legal range 4..2^19-1; held constant while a frame is in progress.
REQ-006 EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 PEN  in  1  1 = parity bit present after the data bits.
REQ-008 OHEL  in  1  1 = odd parity, 0 = even parity.
REQ-009 CLR_RDY  in  1  single-cycle pulse; host has read the data.
REQ-010 RDATA  out  8  received data; bit7 is forced to 0 when EIGHT=0.
REQ-011 RXRDY  out  1  a frame is held in RDATA and has not been read.
REQ-012 PERR  out  1  parity error flag for the held frame.
REQ-013 FERR  out  1  framing error flag for the held frame.
REQ-014 OVF  out  1  overflow flag; set when a frame completes while RXRDY=1.

Function
REQ-015 States: IDLE, START, DATA, STOP.
- Bit counter: bitcnt.
- Timer: 19-bit down-counter, tmr.
REQ-016 IDLE: when RX is sampled low, go to START and load tmr = K>>1.
REQ-017 START: when tmr reaches 0, resample RX.
- RX low: go to DATA, load tmr = K.
- RX high (false start): return to IDLE; no flag changes.
REQ-018 DATA: sample RX each time tmr reaches 0, then reload tmr = K.
- Samples shift in LSB first.
- Sample count is N = 7 + EIGHT + PEN.
REQ-019 After the N-th sample, go to STOP with tmr = K.
REQ-020 STOP: when tmr reaches 0, sample the stop bit. In that same cycle:
- latch RDATA;
- set RXRDY=1;
- latch PERR and FERR;
- return to IDLE.
REQ-021 FERR = stop sample is 0.
REQ-022 Parity:
- expected bit = ^data for even (OHEL=0), ~^data for odd (OHEL=1).
- data = 7 or 8 bits per EIGHT.
- PERR = PEN & (received parity bit != expected bit).
- PERR = 0 when PEN=0.
REQ-023 OVF is set in the STOP completion cycle if RXRDY was already 1; the new frame overwrites RDATA, PERR and FERR.
REQ-024 CLR_RDY clears RXRDY and OVF on the next edge.
REQ-025 CLR_RDY and STOP completion in the same cycle: completion wins.
- RXRDY=1.
- OVF takes its pre-clear RXRDY evaluation, i.e. OVF=1 if RXRDY was 1.
REQ-026 EIGHT, PEN and OHEL are sampled at the START->DATA transition and held internally for the rest of the frame.
REQ-027 Latency: RXRDY rises exactly K/2 + (N+1)*K + 1 clk cycles after the first low RX sample (integer K/2), excluding synchronizer delay.

Reset
REQ-028 On reset assertion, all of the following clear immediately, including mid-frame:
- state=IDLE;
- tmr=0, bitcnt=0;
- RDATA=8'h00;
- RXRDY=0, PERR=0, FERR=0, OVF=0.
REQ-029 After reset release, a partially received frame is discarded; reception resumes at the next falling edge of RX while in IDLE.

Configuration
REQ-030 Macro RX_SYNC_EN selects the RX input path.
- Defined: RX passes through a two-flop synchronizer, reset to 1, before use. All RX-relative timing is delayed by 2 clk cycles.
- Undefined: RX is used directly; the design must then be fed a synchronous RX.

Verification
REQ-031 K=16, EIGHT=1, PEN=1, OHEL=0, frame 0x55 with parity 0 and stop 1 -> RDATA=8'h55, RXRDY=1, PERR=0, FERR=0.
REQ-032 Same settings, frame 0x55 with parity bit 1 -> PERR=1, RDATA=8'h55; then pulse CLR_RDY -> RXRDY=0.
REQ-033 K=16, EIGHT=0, PEN=0, frame 7'h41 with stop bit 0 -> RDATA=8'h41, FERR=1, PERR=0.
REQ-034 Two frames, 0x12 then 0x34, without CLR_RDY -> RDATA=8'h34, OVF=1; then CLR_RDY -> OVF=0, RXRDY=0.
REQ-035 RX low for 4 cycles only with K=16 -> false start; state returns to IDLE, all flags stay 0.
REQ-036 Assert reset midway through the DATA bits -> all outputs 0 immediately; after release, a clean frame 0xA5 is received correctly.
